// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 16-point pipelined FFT: gathers serial samples into a
// parallel frame, waits out the pipeline latency, then streams the bins back out.
module fft_frame_ctrl #(
  parameter int DATA_W   = 16,
  parameter int N        = 16,
  parameter int PIPE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_im,
  output logic [N*DATA_W-1:0] fft_in_real,
  output logic [N*DATA_W-1:0] fft_in_im,
  output logic                fft_launch,
  input  logic [N*DATA_W-1:0] fft_out_real,
  input  logic [N*DATA_W-1:0] fft_out_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_real,
  output logic [DATA_W-1:0]   out_im,
  output logic                out_last,
  output logic                busy,
  output logic [15:0]         frame_count
);

  localparam int IDX_W = $clog2(N);
  localparam int LAT_W = $clog2(PIPE_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(PIPE_LAT);

  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_e;

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic              in_hs, out_hs, capture;

  logic [DATA_W-1:0] fb_re [N];
  logic [DATA_W-1:0] fb_im [N];
  logic [DATA_W-1:0] ob_re [N];
  logic [DATA_W-1:0] ob_im [N];

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign capture = (state == WAIT) && (lat_cnt == LAT_END);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // NOTE: next state defaults to the current state so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_hs && wr_idx == LAST_IDX) state_nxt = WAIT;
      WAIT:    if (lat_cnt == LAT_END)          state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last)          state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready   = rst_n && (state == LOAD);
    busy       = (state == WAIT) || (state == DRAIN);
    out_valid  = (state == DRAIN);
    fft_launch = (state == WAIT) && (lat_cnt == '0);
    out_last   = (state == DRAIN) && (rd_idx == LAST_IDX);
    out_real   = (state == DRAIN) ? ob_re[rd_idx] : '0;
    out_im     = (state == DRAIN) ? ob_im[rd_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      rd_idx      <= '0;
      lat_cnt     <= '0;
      frame_count <= '0;
    end else begin
      if (in_hs) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      lat_cnt <= (state == WAIT && lat_cnt != LAT_END) ? lat_cnt + 1'b1 : '0;
      if (capture)     rd_idx <= '0;
      else if (out_hs) rd_idx <= out_last ? '0 : rd_idx + 1'b1;
      if (out_hs && out_last) frame_count <= frame_count + 16'd1;
    end
  end

  // NOTE: the frame buffer drives fft_in_* directly, so it is reset to keep the pipeline input defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        fb_re[k] <= '0;
        fb_im[k] <= '0;
      end
    end else if (in_hs) begin
      fb_re[wr_idx] <= in_real;
      fb_im[wr_idx] <= in_im;
    end
  end

  // Output buffer is only observed in DRAIN, after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        ob_re[k] <= fft_out_real[k*DATA_W +: DATA_W];
        ob_im[k] <= fft_out_im[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    fft_in_real = '0;
    fft_in_im   = '0;
    for (int k = 0; k < N; k++) begin
      fft_in_real[k*DATA_W +: DATA_W] = fb_re[k];
      fft_in_im[k*DATA_W +: DATA_W]   = fb_im[k];
    end
  end

endmodule
